// File: rtl/stopwatch_display.sv
// Scanned 4-digit 7-segment driver with blink of the field under adjustment.
// Optional: define LEADING_ZERO_BLANK_EN to suppress a zero minutes-tens digit.
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] min_tenth,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tenth,
  input  logic [3:0] sec_ones,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blk_cnt;
  logic [1:0]    idx;
  logic          blink_phase;

  logic       ref_tc;
  logic       blk_tc;
  logic       blink_next;
  logic       lz_blank;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] glyph;
  logic [3:0] an_next;
  logic [7:0] seg_next;

  assign ref_tc = (ref_cnt == RW'(REFRESH_DIV - 1));
  assign blk_tc = (blk_cnt == BW'(BLINK_DIV - 1));

  // a slot starting on a blink toggle sees the new phase
  assign blink_next = blk_tc ? ~blink_phase : blink_phase;

  always_comb begin
    digit = sec_ones;
    unique case (idx)
      2'd0: digit = sec_ones;
      2'd1: digit = sec_tenth;
      2'd2: digit = min_ones;
      2'd3: digit = min_tenth;
    endcase
  end

  always_comb begin
    glyph = 7'b0111111;
    case (digit)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx == 2'd3) && (min_tenth == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  assign blank = lz_blank |
    (adj & blink_next & (sel ? ~idx[1] : idx[1]));

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 8'hFF;
    if (!blank) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = {(idx != 2'd2), glyph};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_cnt     <= '0;
      blk_cnt     <= '0;
      idx         <= 2'd0;
      blink_phase <= 1'b0;
      an          <= 4'b1111;
      seg         <= 8'hFF;
    end else begin
      ref_cnt     <= ref_tc ? '0 : ref_cnt + RW'(1);
      blk_cnt     <= blk_tc ? '0 : blk_cnt + BW'(1);
      blink_phase <= blink_next;
      if (ref_tc) begin
        idx <= idx + 2'd1;
        an  <= an_next;
        seg <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display at REFRESH_DIV=4, BLINK_DIV=16.
// Expected scan values come from a cycle-count model of the display.
module tb_stopwatch_display;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] min_tenth = 4'd1;
  logic [3:0] min_ones  = 4'd2;
  logic [3:0] sec_tenth = 4'd3;
  logic [3:0] sec_ones  = 4'd4;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;

  int n_chk  = 0;
  int n_pass = 0;

  stopwatch_display #(
    .REFRESH_DIV(4),
    .BLINK_DIV(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .min_tenth(min_tenth),
    .min_ones(min_ones),
    .sec_tenth(sec_tenth),
    .sec_ones(sec_ones),
    .adj(adj),
    .sel(sel),
    .an(an),
    .seg(seg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d > 4'd9) ? 7'h3F : tbl[d];
  endfunction

  // reference model: edges since release define slot and blink phase
  int n = 0;
  logic [11:0] exp_out = 12'hFFF;
  logic [11:0] sbq [$];

  always @(posedge clock) begin
    if (!reset) begin
      n = 0;
      exp_out = 12'hFFF;
      sbq.delete();
    end else begin
      n++;
      if (n % 4 == 0) begin
        int slot;
        int ph;
        logic [3:0] d;
        logic bl;
        slot = ((n / 4) - 1) % 4;
        ph = (n / 16) % 2;
        case (slot)
          0: d = sec_ones;
          1: d = sec_tenth;
          2: d = min_ones;
          default: d = min_tenth;
        endcase
        bl = adj && (ph == 1) && (sel ? (slot < 2) : (slot >= 2));
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 3 && min_tenth == 4'd0) bl = 1'b1;
`endif
        if (bl) exp_out = 12'hFFF;
        else exp_out = {~(4'b0001 << slot), (slot != 2), glyph_of(d)};
      end
      sbq.push_back(exp_out);
    end
  end

  always @(negedge clock) begin
    if (!reset) chk("reset", {an, seg}, 12'hFFF);
    else if (sbq.size() > 0) chk("scan", {an, seg}, sbq.pop_front());
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
    #1;
  endtask

  initial begin
    bit found;
    cyc(10);
    reset = 1'b1;
    cyc(48);
    sec_ones = 4'd12;
    cyc(32);
    sec_ones = 4'd4;
    adj = 1'b1;
    sel = 1'b1;
    cyc(64);
    sel = 1'b0;
    cyc(64);
    adj = 1'b0;
    cyc(32);
    // mid-slot change of sec_ones
    cyc(2);
    sec_ones = 4'd7;
    cyc(32);
    for (int i = 0; i < 200; i++) begin
      min_tenth = 4'($urandom_range(0, 15));
      min_ones  = 4'($urandom_range(0, 15));
      sec_tenth = 4'($urandom_range(0, 15));
      sec_ones  = 4'($urandom_range(0, 15));
      adj = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 6));
    end
    min_tenth = 4'd0;
    min_ones  = 4'd5;
    sec_tenth = 4'd9;
    sec_ones  = 4'd8;
    adj = 1'b0;
    cyc(48);
    // asynchronous reset in the middle of slot 2
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (n % 16 == 13) found = 1'b1;
      else cyc(1);
    end
    chk("find_slot2", {11'd0, found}, 12'd1);
    chk("slot2_on", {an, seg}, {4'b1011, 1'b0, glyph_of(min_ones)});
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst", {an, seg}, 12'hFFF);
    cyc(5);
    reset = 1'b1;
    cyc(40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Scanned 4-digit 7-segment display driver; consumes the stopwatch counter's BCD digits (min_tenth, min_ones, sec_tenth, sec_ones) together with the adj/sel controls.
- Time-multiplexes the digits onto shared active-low cathodes with active-low anodes.
- Blinks the field selected for adjustment.
- Sits between the counter and the board's display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (250 Hz per digit at 100 MHz); minimum 2.
- BLINK_DIV, 25000000, clock cycles per blink half-period (2 Hz toggle at 100 MHz); minimum 2.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- min_tenth  input  4  minutes tens digit, BCD
- min_ones  input  4  minutes ones digit, BCD
- sec_tenth  input  4  seconds tens digit, BCD
- sec_ones  input  4  seconds ones digit, BCD
- adj  input  1  adjust mode; enables blinking
- sel  input  1  adjust field: 1 = seconds, 0 = minutes
- an  output  4  digit anodes, active-low; an[0] = sec_ones … an[3] = min_tenth
- seg  output  8  cathodes, active-low; seg[7] = dp, seg[6:0] = {g,f,e,d,c,b,a}

Behaviour:
- Reset (reset=0, asynchronous): an=4'b1111, seg=8'hFF, refresh counter=0, digit index=0, blink_phase=0.
  - Outputs return to driving one cycle after the first refresh terminal count following reset release.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - At terminal count (value REFRESH_DIV-1), digit index advances 0→1→2→3→0.
- Blink counter:
  - Counts 0..BLINK_DIV-1, then wraps.
  - At terminal count, blink_phase toggles.
  - Free-running, independent of adj.
- Sampling:
  - On the refresh terminal-count edge, the input digit for the next index is sampled into a register.
  - an and seg are registered and update on the same edge, so there is one-cycle latency from terminal count to output change.
  - Input changes mid-slot are not visible until that digit's next slot.
- Anodes: slot i drives an = ~(1<<i), unless blanked.
- Decode (active-low, dp excluded):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 decode to a dash: 0111111.
- Decimal point: seg[7]=0 only in slot 2 (minutes/seconds separator); 1 otherwise.
- Blanking: when adj=1 and blink_phase=1:
  - sel=1: slots 0,1 drive an=1111, seg=8'hFF.
  - sel=0: slots 2,3 drive an=1111, seg=8'hFF.
  - The dp blanks with its digit.
  - adj and sel are sampled with the digit value at slot start.
- Simultaneous refresh and blink terminal count: the new slot uses the updated blink_phase.
- Never more than one anode low at any time.
- No glitch cycles between slots; an and seg transition together.
- Reset asserted mid-slot forces outputs off immediately; the scan restarts at slot 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the sampled min_tenth==0, slot 3 drives an=1111, seg=8'hFF (leading zero suppressed). Other slots are unaffected. Blink rules still apply to the remaining digits.
- Undefined: min_tenth 0 displays as "0" (seg=8'hC0).

Test Plan (REFRESH_DIV=4, BLINK_DIV=16 unless stated):
- Reset held low 10 cycles → an=1111, seg=FF throughout. Release → first change one cycle after cycle 4: an=1110.
- Digits min 1,2 / sec 3,4, adj=0 → repeating scan an=1110/seg=99, an=1101/seg=B0, an=1011/seg=24 (dp on), an=0111/seg=F9; each slot lasts 4 cycles.
- sec_ones=4'd12 → slot 0 seg=BF (dash); other digits unchanged.
- adj=1, sel=1, digits 1234 → slots 0,1 fully off (an=1111, seg=FF) during blink_phase=1, normal during blink_phase=0; slots 2,3 always normal. Switch to sel=0 → slots 2,3 blink instead. adj=0 → no blanking.
- sec_ones changed 4→7 mid-slot 0 → seg stays 99 until slot 0 recurs, then F8.
- reset pulled low during slot 2 → an=1111 and seg=FF in the same cycle, asynchronously. Release → scan restarts at slot 0.
- With LEADING_ZERO_BLANK_EN defined, min_tenth=0 → slot 3 an=1111, seg=FF. Undefined → an=0111, seg=C0.
